mips_fetch_unit: RTL
====================

// Module: mips_fetch_unit
// PURPOSE
//   Instruction-fetch front end feeding the MIPS datapath's instruction input.
//   Holds the PC and issues word reads to instruction memory over a req/ack handshake.
//   Presents each fetched word to the datapath over a valid/ready handshake.
//   Accepts branch/jump redirects from the datapath and discards stale fetches.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset; bits [1:0] must be 0
//   CNT_W      16             width of fetched-instruction counter
// PORTS
//   clk           in   1      rising-edge clock
//   reset         in   1      asynchronous, active-high reset
//   imem_req      out  1      read request to instruction memory
//   imem_addr     out  32     byte address of request; word aligned
//   imem_ack      in   1      memory response strobe; imem_rdata valid this cycle
//   imem_rdata    in   32     instruction word returned by memory
//   instr_valid   out  1      instruction/instr_pc hold a valid fetched word
//   instr_ready   in   1      datapath consumes the word this cycle
//   instruction   out  32     fetched instruction word
//   instr_pc      out  32     address the presented instruction was fetched from
//   redirect      in   1      branch/jump taken; restart fetch at redirect_pc
//   redirect_pc   in   32     redirect target address
//   misalign_err  out  1      1-cycle pulse: redirect_pc[1:0] != 0
//   fetch_count   out  CNT_W  count of instructions consumed (valid & ready)
// BEHAVIOUR
//   Reset (async): pc=RESET_PC; state=IDLE; imem_req=0, imem_addr=RESET_PC,
//     instr_valid=0, instruction=0, instr_pc=0, misalign_err=0, fetch_count=0, discard=0.
//   FSM states: IDLE, REQ, HOLD.
//     IDLE: leave on first clk after reset release -> REQ, imem_req=1, imem_addr=pc.
//     REQ:  imem_req and imem_addr held stable until imem_ack; no abort of request.
//       On ack with discard=0: instruction<=imem_rdata, instr_pc<=pc, pc<=pc+4,
//       instr_valid<=1 -> HOLD. Ack to instr_valid latency: 1 cycle.
//       On ack with discard=1: data dropped, discard<=0, new REQ at pc next cycle.
//     HOLD: instr_valid=1, outputs stable until instr_ready.
//       On instr_ready: fetch_count++, instr_valid<=0, -> REQ with imem_addr=pc.
//       Min throughput: one instruction every 3 cycles at 1-cycle memory ack.
//   Redirect (any state, highest priority): pc<={redirect_pc[31:2],2'b00}.
//     HOLD: held word dropped; instr_valid<=0; no count even if instr_ready=1; -> REQ.
//     REQ, ack not this cycle: discard<=1; stay REQ on old address until ack.
//     REQ, ack same cycle: returned word dropped; -> REQ at new pc next cycle.
//     IDLE: pc updated; -> REQ at new pc.
//     redirect_pc[1:0]!=0: misalign_err=1 next cycle for one cycle; low bits cleared.
//   Arithmetic: pc+4 modulo 2^32 (FFFF_FFFC -> 0000_0000); fetch_count wraps at 2^CNT_W.
//   imem_ack outside REQ ignored. Reset mid-request: state forced to IDLE; next
//     ack from memory before new imem_req is ignored.
// TESTING
//   Reset, ack 1 cycle after each req, ready=1: addrs 0,4,8; instr_valid 1 cycle after ack; fetch_count=3.
//   Ack delayed 5 cycles, ready held 0 for 4 cycles: imem_addr stable; instruction/instr_pc stable until ready.
//   Redirect to 0x100 while REQ at 0x8 outstanding: ack data dropped, next imem_addr=0x100, instr_pc=0x100.
//   Redirect to 0x40 in HOLD with instr_ready=1 same cycle: no count; instr_valid drops; next req 0x40.
//   Redirect to 0x102: misalign_err single pulse; next imem_addr=0x100.
//   Redirect to 0xFFFF_FFFC, consume two words: instr_pc 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC holder and instruction fetcher with req/ack memory side,
// valid/ready datapath side, and redirects that discard stale fetches.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instruction,
  output logic [31:0]      instr_pc,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t           r_state;
  logic [31:0]      r_pc, r_addr, r_instr, r_ipc;
  logic             r_req, r_valid, r_mis, r_discard;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_rpc;
  assign w_rpc        = {redirect_pc[31:2], 2'b00};
  assign imem_req     = r_req;
  assign imem_addr    = r_addr;
  assign instr_valid  = r_valid;
  assign instruction  = r_instr;
  assign instr_pc     = r_ipc;
  assign misalign_err = r_mis;
  assign fetch_count  = r_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_addr    <= RESET_PC;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_ipc     <= '0;
      r_mis     <= 1'b0;
      r_cnt     <= '0;
      r_discard <= 1'b0;
    end else begin
      r_mis <= redirect && (redirect_pc[1:0] != 2'b00);
      if (redirect) begin
        r_pc    <= w_rpc;
        r_valid <= 1'b0;
        // An outstanding request cannot be aborted, so its reply is marked stale
        if (r_state == REQ && !imem_ack)
          r_discard <= 1'b1;
        else begin
          r_state   <= REQ;
          r_req     <= 1'b1;
          r_addr    <= w_rpc;
          r_discard <= 1'b0;
        end
      end else
        case (r_state)
          IDLE: begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
          REQ:
            if (imem_ack) begin
              if (r_discard) begin
                r_discard <= 1'b0;
                r_addr    <= r_pc;
              end else begin
                r_instr <= imem_rdata;
                r_ipc   <= r_pc;
                r_pc    <= r_pc + 32'd4;
                r_valid <= 1'b1;
                r_req   <= 1'b0;
                r_state <= HOLD;
              end
            end
          HOLD:
            if (instr_ready) begin
              r_cnt   <= r_cnt + 1'b1;
              r_valid <= 1'b0;
              r_req   <= 1'b1;
              r_addr  <= r_pc;
              r_state <= REQ;
            end
          default: r_state <= IDLE;
        endcase
    end
endmodule
